// File: rtl/cfs_md_pkg.sv
// Shared types and MD transfer helpers for the CFS realigner family.
package cfs_md_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        FLUSH = 2'd2
    } md_state_e;

    function automatic logic is_legal(input int unsigned offset, input int unsigned size,
                                      input int unsigned bytes);
        if (size == 0) return 1'b0;
        return (offset + size <= bytes) && ((offset % size) == 0);
    endfunction

    // Flush emits power-of-two chunks only, so every chunk stays naturally aligned.
    // avail must already be bounded by the lanes left above the offset.
    function automatic int unsigned flush_size(input int unsigned offset, input int unsigned avail);
        int unsigned s;
        s = 1;
        for (int i = 1; i < 8; i++) begin
            if (((32'd1 << i) <= avail) && ((offset & ((32'd1 << i) - 32'd1)) == 0)) begin
                s = 32'd1 << i;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/cfs_md_realigner_if.sv
// MD_RX / MD_TX handshake bundle; slave is the realigner side, master the environment side.
interface cfs_md_realigner_if #(
    parameter int ALGN_DATA_WIDTH = 32
);
    localparam int BYTES = ALGN_DATA_WIDTH / 8;
    localparam int OW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int SW    = $clog2(BYTES) + 1;

    logic                       md_rx_valid;
    logic [ALGN_DATA_WIDTH-1:0] md_rx_data;
    logic [OW-1:0]              md_rx_offset;
    logic [SW-1:0]              md_rx_size;
    logic                       md_rx_ready;
    logic                       md_rx_err;

    logic                       md_tx_valid;
    logic [ALGN_DATA_WIDTH-1:0] md_tx_data;
    logic [OW-1:0]              md_tx_offset;
    logic [SW-1:0]              md_tx_size;
    logic                       md_tx_ready;
    logic                       md_tx_err;

    modport master (
        output md_rx_valid, md_rx_data, md_rx_offset, md_rx_size,
        input  md_rx_ready, md_rx_err,
        input  md_tx_valid, md_tx_data, md_tx_offset, md_tx_size,
        output md_tx_ready, md_tx_err
    );

    modport slave (
        input  md_rx_valid, md_rx_data, md_rx_offset, md_rx_size,
        output md_rx_ready, md_rx_err,
        output md_tx_valid, md_tx_data, md_tx_offset, md_tx_size,
        input  md_tx_ready, md_tx_err
    );

endinterface

// File: rtl/cfs_md_byte_buf.sv
// Byte FIFO kept as a packed shift vector: oldest byte at lane 0, unused bytes held at zero.
module cfs_md_byte_buf
    import cfs_md_pkg::*;
#(
    parameter  int BYTES = 4,
    parameter  int CAP   = 8,
    localparam int SW    = $clog2(BYTES) + 1,
    localparam int CW    = $clog2(CAP + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [8*BYTES-1:0] push_data_i,
    input  logic [SW-1:0]      push_n_i,
    input  logic [SW-1:0]      pop_n_i,
    output logic [8*BYTES-1:0] head_o,
    output logic [CW-1:0]      count_o,
    output logic [CW-1:0]      count_nxt_o
);

    logic [8*CAP-1:0] mem_q, mem_d, push_ext;
    logic [CW-1:0]    count_q, count_d, keep;

    // Pop shifts the survivors down; pushed bytes land right above them.
    always_comb begin
        keep     = count_q - CW'(pop_n_i);
        push_ext = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i < int'(push_n_i)) push_ext[8*i +: 8] = push_data_i[8*i +: 8];
        end
        mem_d   = (mem_q >> (8 * int'(pop_n_i))) | (push_ext << (8 * int'(keep)));
        count_d = keep + CW'(push_n_i);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q   <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign head_o      = mem_q[8*BYTES-1:0];
    assign count_o     = count_q;
    assign count_nxt_o = count_d;

endmodule

// File: rtl/cfs_md_realigner.sv
// Repacks variable-size MD_RX transfers into MD_TX transfers of the configured size/offset.
module cfs_md_realigner
    import cfs_md_pkg::*;
#(
    parameter  int ALGN_DATA_WIDTH = 32,
    parameter  int BUF_WORDS       = 2,
    parameter  int CNT_WIDTH       = 8,
    localparam int BYTES           = ALGN_DATA_WIDTH / 8,
    localparam int OW              = (BYTES > 1) ? $clog2(BYTES) : 1,
    localparam int SW              = $clog2(BYTES) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cfs_md_realigner_if.slave    md,
    input  logic [OW-1:0]        cfg_offset,
    input  logic [SW-1:0]        cfg_size,
    input  logic                 flush,
    input  logic                 cnt_clr,
    output logic                 cfg_err,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] rx_drop_cnt,
    output logic [CNT_WIDTH-1:0] tx_err_cnt
);

    localparam int CAP = BUF_WORDS * BYTES;
    localparam int CW  = $clog2(CAP + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    md_state_e                  state_q;
    logic                       tx_valid_q;
    logic [ALGN_DATA_WIDTH-1:0] tx_data_q;
    logic [OW-1:0]              tx_offset_q;
    logic [SW-1:0]              tx_size_q;
    logic [OW-1:0]              off_q;
    logic                       rx_ready_q;
    logic                       flush_pend_q;
    logic [CNT_WIDTH-1:0]       rx_drop_cnt_q;
    logic [CNT_WIDTH-1:0]       tx_err_cnt_q;

    logic                       rx_fire, rx_legal, rx_drop, tx_fire;
    logic                       send_ok;
    logic [ALGN_DATA_WIDTH-1:0] push_data, head, masked, ld_data;
    logic [SW-1:0]              push_n, pop_n, ld_size;
    logic [OW-1:0]              ld_off;
    logic [CW-1:0]              count, count_nxt;
    int unsigned                avail;

    cfs_md_byte_buf #(
        .BYTES (BYTES),
        .CAP   (CAP)
    ) u_buf (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_data_i (push_data),
        .push_n_i    (push_n),
        .pop_n_i     (pop_n),
        .head_o      (head),
        .count_o     (count),
        .count_nxt_o (count_nxt)
    );

    always_comb begin
        rx_fire   = md.md_rx_valid && rx_ready_q;
        rx_legal  = is_legal(32'(md.md_rx_offset), 32'(md.md_rx_size), BYTES);
        rx_drop   = rx_fire && !rx_legal;
        push_n    = (rx_fire && rx_legal) ? md.md_rx_size : '0;
        push_data = md.md_rx_data >> (8 * 32'(md.md_rx_offset));
        tx_fire   = tx_valid_q && md.md_tx_ready;
        pop_n     = tx_fire ? tx_size_q : '0;
        cfg_err   = !is_legal(32'(cfg_offset), 32'(cfg_size), BYTES);
        send_ok   = !cfg_err && (32'(count) >= 32'(cfg_size));

        // Leaving IDLE uses the live config; later FLUSH chunks reuse the captured offset.
        ld_off = (state_q == IDLE) ? cfg_offset : off_q;
        avail  = BYTES - 32'(ld_off);
        if (32'(count) < avail) avail = 32'(count);
        if (state_q == IDLE && send_ok) ld_size = cfg_size;
        else                            ld_size = SW'(flush_size(32'(ld_off), avail));

        masked = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i < int'(ld_size)) masked[8*i +: 8] = head[8*i +: 8];
        end
        ld_data = masked << (8 * 32'(ld_off));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            tx_offset_q  <= '0;
            tx_size_q    <= '0;
            off_q        <= '0;
            rx_ready_q   <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            rx_ready_q <= (count_nxt <= CW'(CAP - BYTES));
            case (state_q)
                IDLE: begin
                    if (send_ok || (!cfg_err && flush_pend_q && count != '0)) begin
                        state_q     <= send_ok ? SEND : FLUSH;
                        tx_valid_q  <= 1'b1;
                        tx_data_q   <= ld_data;
                        tx_offset_q <= ld_off;
                        tx_size_q   <= ld_size;
                        off_q       <= ld_off;
                    end
                end
                SEND: begin
                    if (tx_fire) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                FLUSH: begin
                    if (tx_valid_q) begin
                        if (tx_fire) tx_valid_q <= 1'b0;
                    end else if (count == '0) begin
                        state_q      <= IDLE;
                        flush_pend_q <= 1'b0;
                    end else begin
                        tx_valid_q  <= 1'b1;
                        tx_data_q   <= ld_data;
                        tx_offset_q <= ld_off;
                        tx_size_q   <= ld_size;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (flush && count != '0) flush_pend_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_drop_cnt_q <= '0;
            tx_err_cnt_q  <= '0;
        end else begin
            if (cnt_clr)                                   rx_drop_cnt_q <= '0;
            else if (rx_drop && rx_drop_cnt_q != CNT_MAX)  rx_drop_cnt_q <= rx_drop_cnt_q + 1'b1;
            if (cnt_clr)                                   tx_err_cnt_q <= '0;
            else if (tx_fire && md.md_tx_err && tx_err_cnt_q != CNT_MAX)
                                                           tx_err_cnt_q <= tx_err_cnt_q + 1'b1;
        end
    end

    assign md.md_rx_ready  = rx_ready_q;
    assign md.md_rx_err    = rx_drop;
    assign md.md_tx_valid  = tx_valid_q;
    assign md.md_tx_data   = tx_data_q;
    assign md.md_tx_offset = tx_offset_q;
    assign md.md_tx_size   = tx_size_q;
    assign busy            = (count != '0) || tx_valid_q;
    assign rx_drop_cnt     = rx_drop_cnt_q;
    assign tx_err_cnt      = tx_err_cnt_q;

endmodule

// File: tb/tb_cfs_md_realigner.sv
// Directed + randomized bench for cfs_md_realigner against a byte-queue reference model.
module tb_cfs_md_realigner;
    localparam int W     = 32;
    localparam int BYTES = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [1:0] cfg_offset;
    logic [2:0] cfg_size;
    logic       flush, cnt_clr, cfg_err, busy;
    logic [7:0] rx_drop_cnt, tx_err_cnt;

    cfs_md_realigner_if #(.ALGN_DATA_WIDTH(W)) md();

    cfs_md_realigner #(.ALGN_DATA_WIDTH(W), .BUF_WORDS(2), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .md(md),
        .cfg_offset(cfg_offset), .cfg_size(cfg_size), .flush(flush), .cnt_clr(cnt_clr),
        .cfg_err(cfg_err), .busy(busy), .rx_drop_cnt(rx_drop_cnt), .tx_err_cnt(tx_err_cnt)
    );

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [7:0]  q_bytes[$];
    logic [31:0] tx_log_data[$];
    int          tx_log_size[$];
    int          drop_m = 0, txerr_m = 0;
    int          cur_off = 0, cur_size = 4;
    bit          flush_mode = 0;
    bit          hold_p = 0;
    logic [31:0] hold_data;
    int          hold_off, hold_size;
    bit          saw_nr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal_m(input int off, input int size);
        return size > 0 && off + size <= BYTES && off % size == 0;
    endfunction

    function automatic int flush_m(input int off, input int len);
        int lim = len;
        if (BYTES - off < lim) lim = BYTES - off;
        for (int s = lim; s >= 1; s--) begin
            if ((s & (s - 1)) == 0 && off % s == 0) return s;
        end
        return 1;
    endfunction

    task automatic set_cfg(input int off, input int size);
        cfg_offset = 2'(off);
        cfg_size   = 3'(size);
        cur_off    = off;
        cur_size   = size;
    endtask

    task automatic cycle(input bit rv, input logic [31:0] rd, input int ro, input int rs,
                         input bit trdy, input bit terr, input bit fl, input bit clr);
        @(negedge clk);
        md.md_rx_valid  = rv;
        md.md_rx_data   = rd;
        md.md_rx_offset = 2'(ro);
        md.md_rx_size   = 3'(rs);
        md.md_tx_ready  = trdy;
        md.md_tx_err    = terr;
        flush           = fl;
        cnt_clr         = clr;
        #1;
        if (hold_p) begin
            chk("tx_hold_valid", 64'(md.md_tx_valid), 64'd1);
            chk("tx_hold_data", 64'(md.md_tx_data), 64'(hold_data));
            chk("tx_hold_offset", 64'(md.md_tx_offset), 64'(hold_off));
            chk("tx_hold_size", 64'(md.md_tx_size), 64'(hold_size));
        end
        if (md.md_tx_valid && trdy) begin
            int sz = int'(md.md_tx_size);
            int exp_sz = flush_mode ? flush_m(cur_off, q_bytes.size()) : cur_size;
            logic [31:0] exp_d = '0;
            chk("tx_size", 64'(sz), 64'(exp_sz));
            chk("tx_offset", 64'(md.md_tx_offset), 64'(cur_off));
            if (q_bytes.size() < sz || cur_off + sz > BYTES) begin
                chk("tx_underrun", 64'(q_bytes.size()), 64'(sz));
            end else begin
                for (int i = 0; i < sz; i++) exp_d[8*(cur_off+i) +: 8] = q_bytes.pop_front();
                chk("tx_data", 64'(md.md_tx_data), 64'(exp_d));
            end
            tx_log_data.push_back(md.md_tx_data);
            tx_log_size.push_back(sz);
            if (terr && txerr_m < 255) txerr_m++;
        end
        if (rv && md.md_rx_ready) begin
            bit lg = legal_m(ro, rs);
            chk("rx_err", 64'(md.md_rx_err), 64'(!lg));
            if (lg) for (int i = ro; i < ro + rs; i++) q_bytes.push_back(rd[8*i +: 8]);
            else if (drop_m < 255) drop_m++;
        end else begin
            chk("rx_err_idle", 64'(md.md_rx_err), 64'd0);
        end
        if (clr) begin
            drop_m  = 0;
            txerr_m = 0;
        end
        if (!md.md_rx_ready) saw_nr = 1;
        hold_p    = md.md_tx_valid && !trdy;
        hold_data = md.md_tx_data;
        hold_off  = int'(md.md_tx_offset);
        hold_size = int'(md.md_tx_size);
    endtask

    task automatic idle(input int n, input bit trdy);
        for (int i = 0; i < n; i++) cycle(0, 32'h0, 0, 0, trdy, 0, 0, 0);
    endtask

    task automatic run_until_tx(input int want, input int budget);
        int b = budget;
        while (tx_log_data.size() < want && b > 0) begin
            cycle(0, 32'h0, 0, 0, 1, 0, 0, 0);
            b--;
        end
        chk("tx_count", 64'(tx_log_data.size()), 64'(want));
    endtask

    task automatic drain(input int budget);
        int b = budget;
        while (busy && b > 0) begin
            cycle(0, 32'h0, 0, 0, 1, 0, 0, 0);
            b--;
        end
        chk("drain_busy", 64'(busy), 64'd0);
        chk("drain_model_empty", 64'(q_bytes.size()), 64'd0);
    endtask

    initial begin
        int off, size, tries, pick, b;
        int ill_off[4]  = '{1, 3, 2, 0};
        int ill_size[4] = '{2, 2, 4, 0};
        int cfg_off[7]  = '{0, 1, 3, 0, 2, 0, 0};
        int cfg_sz[7]   = '{1, 1, 1, 2, 2, 4, 3};

        reset_n = 1'b0;
        md.md_rx_valid = 0; md.md_rx_data = '0; md.md_rx_offset = '0; md.md_rx_size = '0;
        md.md_tx_ready = 0; md.md_tx_err = 0; flush = 0; cnt_clr = 0;
        set_cfg(0, 4);
        #12;
        chk("rst_rx_ready", 64'(md.md_rx_ready), 64'd0);
        chk("rst_tx_valid", 64'(md.md_tx_valid), 64'd0);
        chk("rst_tx_data", 64'(md.md_tx_data), 64'd0);
        chk("rst_tx_size", 64'(md.md_tx_size), 64'd0);
        chk("rst_tx_offset", 64'(md.md_tx_offset), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_drop_cnt", 64'(rx_drop_cnt), 64'd0);
        chk("rst_txerr_cnt", 64'(tx_err_cnt), 64'd0);
        chk("rst_cfg_err", 64'(cfg_err), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1, 1);
        chk("first_accept", 64'(md.md_rx_ready), 64'd1);

        // basic repack with latency check
        cycle(1, 32'h0000_0011, 0, 1, 1, 0, 0, 0);
        cycle(1, 32'h0000_2200, 1, 1, 1, 0, 0, 0);
        cycle(1, 32'h0033_0000, 2, 1, 1, 0, 0, 0);
        cycle(1, 32'h4400_0000, 3, 1, 1, 0, 0, 0);
        cycle(0, 32'h0, 0, 0, 0, 0, 0, 0);
        chk("latency_pre", 64'(md.md_tx_valid), 64'd0);
        cycle(0, 32'h0, 0, 0, 0, 0, 0, 0);
        chk("latency_post", 64'(md.md_tx_valid), 64'd1);
        run_until_tx(1, 10);
        if (tx_log_data.size() >= 1) begin
            chk("basic_data", 64'(tx_log_data[0]), 64'h4433_2211);
            chk("basic_size", 64'(tx_log_size[0]), 64'd4);
        end

        // upsize with offset
        tx_log_data.delete(); tx_log_size.delete();
        set_cfg(2, 2);
        cycle(1, 32'hDDCC_BBAA, 0, 4, 1, 0, 0, 0);
        run_until_tx(2, 20);
        if (tx_log_data.size() >= 2) begin
            chk("upsize_data0", 64'(tx_log_data[0]), 64'hBBAA_0000);
            chk("upsize_data1", 64'(tx_log_data[1]), 64'hDDCC_0000);
        end

        // illegal config blocks TX launch, RX keeps working
        tx_log_data.delete(); tx_log_size.delete();
        set_cfg(1, 2);
        cycle(1, 32'h8765_4321, 0, 4, 1, 0, 0, 0);
        chk("cfg_err_set", 64'(cfg_err), 64'd1);
        idle(4, 1);
        chk("cfg_err_no_tx", 64'(md.md_tx_valid), 64'd0);
        set_cfg(0, 4);
        run_until_tx(1, 10);
        if (tx_log_data.size() >= 1) chk("cfg_err_release", 64'(tx_log_data[0]), 64'h8765_4321);

        // illegal RX, saturation, clear with simultaneous drop
        tx_log_data.delete(); tx_log_size.delete();
        cycle(1, 32'h0000_FFFF, 1, 2, 1, 0, 0, 0);
        idle(3, 1);
        chk("drop_one", 64'(rx_drop_cnt), 64'd1);
        chk("drop_no_tx", 64'(tx_log_data.size()), 64'd0);
        chk("drop_not_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 300; i++) begin
            pick = int'($urandom_range(0, 3));
            cycle(1, $urandom, ill_off[pick], ill_size[pick], 1, 0, 0, 0);
        end
        idle(1, 1);
        chk("drop_saturate", 64'(rx_drop_cnt), 64'd255);
        chk("drop_model", 64'(rx_drop_cnt), 64'(drop_m));
        cycle(1, 32'h0, 1, 2, 1, 0, 0, 1);
        idle(1, 1);
        chk("drop_clear", 64'(rx_drop_cnt), 64'd0);

        // flush of a partial word
        tx_log_data.delete(); tx_log_size.delete();
        set_cfg(0, 4);
        cycle(1, 32'h01, 0, 1, 1, 0, 0, 0);
        cycle(1, 32'h02, 0, 1, 1, 0, 0, 0);
        cycle(1, 32'h03, 0, 1, 1, 0, 0, 0);
        idle(3, 1);
        chk("flush_wait", 64'(md.md_tx_valid), 64'd0);
        flush_mode = 1;
        cycle(0, 32'h0, 0, 0, 1, 0, 1, 0);
        run_until_tx(2, 20);
        idle(3, 1);
        flush_mode = 0;
        chk("flush_busy", 64'(busy), 64'd0);
        if (tx_log_data.size() >= 2) begin
            chk("flush_size0", 64'(tx_log_size[0]), 64'd2);
            chk("flush_data0", 64'(tx_log_data[0]), 64'h0201);
            chk("flush_size1", 64'(tx_log_size[1]), 64'd1);
            chk("flush_data1", 64'(tx_log_data[1]), 64'h03);
        end

        // backpressure with RX streaming
        tx_log_data.delete(); tx_log_size.delete();
        saw_nr = 0;
        for (int i = 0; i < 20; i++) cycle(1, $urandom, 0, 4, 0, 0, 0, 0);
        chk("bp_ready_drop", 64'(saw_nr), 64'd1);
        drain(40);
        chk("bp_tx_count", 64'(tx_log_data.size()), 64'd2);

        // randomized phases, each closed with a flush
        for (int ph = 0; ph < 4; ph++) begin
            pick = int'($urandom_range(0, 6));
            set_cfg(cfg_off[pick], cfg_sz[pick]);
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    off  = int'($urandom_range(0, 3));
                    size = int'($urandom_range(0, 4));
                end else begin
                    off = 0; size = 1;
                    for (tries = 0; tries < 16; tries++) begin
                        off  = int'($urandom_range(0, 3));
                        size = int'($urandom_range(1, 4));
                        if (legal_m(off, size)) break;
                    end
                    if (!legal_m(off, size)) begin off = 0; size = 1; end
                end
                cycle($urandom_range(0, 3) != 0, $urandom, off, size,
                      $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0, 0, 0);
            end
            idle(20, 1);
            flush_mode = 1;
            cycle(0, 32'h0, 0, 0, 1, 0, 1, 0);
            drain(40);
            flush_mode = 0;
        end
        chk("rand_txerr_cnt", 64'(tx_err_cnt), 64'(txerr_m));
        chk("rand_drop_cnt", 64'(rx_drop_cnt), 64'(drop_m));

        // reset while a transfer is pending
        set_cfg(0, 4);
        cycle(1, 32'h5566_7788, 0, 4, 0, 0, 0, 0);
        b = 10;
        while (!md.md_tx_valid && b > 0) begin
            cycle(0, 32'h0, 0, 0, 0, 0, 0, 0);
            b--;
        end
        chk("mid_rst_pending", 64'(md.md_tx_valid), 64'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_tx_valid", 64'(md.md_tx_valid), 64'd0);
        chk("mid_rst_tx_data", 64'(md.md_tx_data), 64'd0);
        chk("mid_rst_rx_ready", 64'(md.md_rx_ready), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        q_bytes.delete();
        hold_p = 0; drop_m = 0; txerr_m = 0;
        @(negedge clk);
        reset_n = 1'b1;
        tx_log_data.delete(); tx_log_size.delete();
        idle(1, 1);
        cycle(1, 32'hA1B2_C3D4, 0, 4, 1, 0, 0, 0);
        run_until_tx(1, 10);
        if (tx_log_data.size() >= 1) chk("post_rst_data", 64'(tx_log_data[0]), 64'hA1B2_C3D4);
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
